prbs_checker: RTL and testbench

- Serial receive-side checker for the 4-bit LFSR pattern generator (feedback s[3]^s[2]^s[0], shift right, output s[0]).
- Self-synchronises to the incoming bit stream, flywheels the expected sequence once locked, flags bit errors, counts them and detects loss of sync.
- Sits at the far end of a serial link under test and feeds status LEDs or a register readout.

---
 rtl/prbs_checker_if.sv | 23 ++
 rtl/prbs_checker.sv | 141 ++++++++++++++
 tb/tb_prbs_checker.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/prbs_checker_if.sv
// Status/stream bundle for the 4-bit PRBS checker: received bit stream in,
// lock/error status out.
interface prbs_checker_if #(
  parameter int CNT_W = 16
);
  logic             din;
  logic             din_valid;
  logic             clr_count;
  logic             locked;
  logic             err;
  logic             sync_lost;
  logic [CNT_W-1:0] err_count;

  modport master (
    output din, din_valid, clr_count,
    input  locked, err, sync_lost, err_count
  );

  modport slave (
    input  din, din_valid, clr_count,
    output locked, err, sync_lost, err_count
  );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the 4-bit LFSR stream (b[n+4]=b[n+3]^b[n+2]^b[n]).
// Optional PRBS_ZERO_REJECT_EN: refuse to leave SEED while the history is all zero.
module prbs_checker #(
  parameter int LOCK_CNT   = 8,
  parameter int WINDOW     = 16,
  parameter int UNLOCK_ERR = 4,
  parameter int CNT_W      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  prbs_checker_if.slave bus
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int BW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int EW = $clog2(UNLOCK_ERR + 1);

  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

  state_t           state;
  logic [3:0]       h;
  logic [2:0]       seed_cnt;
  logic [MW-1:0]    match_cnt;
  logic [BW-1:0]    win_bits;
  logic [EW-1:0]    win_errs;
  logic             locked_q;
  logic             err_q;
  logic             sync_lost_q;
  logic [CNT_W-1:0] err_count_q;

  logic             p;
  logic [3:0]       h_din;
  logic [3:0]       h_fly;
  logic             mism;
  logic [EW-1:0]    win_errs_nx;
  logic [MW-1:0]    match_nx;
  logic             seed_done;
  logic             unlock;
  logic             win_end;
  logic             count_err;

  assign p           = h[3] ^ h[2] ^ h[0];
  assign h_din       = {bus.din, h[3:1]};
  assign h_fly       = {p, h[3:1]};
  assign mism        = bus.din != p;
  assign win_errs_nx = win_errs + EW'(mism);
  assign match_nx    = match_cnt + MW'(1);
  assign unlock      = mism && (win_errs_nx == EW'(UNLOCK_ERR));
  assign win_end     = win_bits == BW'(WINDOW - 1);
  assign count_err   = bus.din_valid && (state == LOCKED) && mism;

`ifdef PRBS_ZERO_REJECT_EN
  // Keep seeding past the 4th bit until a non-zero history is captured.
  assign seed_done = (seed_cnt >= 3'd3) && (h_din != 4'd0);
`else
  assign seed_done = (seed_cnt == 3'd3);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEED;
      h           <= '0;
      seed_cnt    <= '0;
      match_cnt   <= '0;
      win_bits    <= '0;
      win_errs    <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      sync_lost_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_q       <= 1'b0;
      sync_lost_q <= 1'b0;

      // Clear takes precedence over a coincident error increment.
      if (bus.clr_count)
        err_count_q <= '0;
      else if (count_err && (err_count_q != '1))
        err_count_q <= err_count_q + CNT_W'(1);

      if (bus.din_valid) begin
        unique case (state)
          SEED: begin
            h <= h_din;
            if (seed_done) begin
              state     <= VERIFY;
              seed_cnt  <= 3'd4;
              match_cnt <= '0;
            end else if (seed_cnt != 3'd4) begin
              seed_cnt <= seed_cnt + 3'd1;
            end
          end

          VERIFY: begin
            // A mismatch simply re-seeds from the received bits.
            h <= h_din;
            if (mism) begin
              match_cnt <= '0;
            end else if (match_nx == MW'(LOCK_CNT)) begin
              state     <= LOCKED;
              locked_q  <= 1'b1;
              match_cnt <= '0;
              win_bits  <= '0;
              win_errs  <= '0;
            end else begin
              match_cnt <= match_nx;
            end
          end

          LOCKED: begin
            err_q <= mism;
            if (unlock) begin
              state       <= SEED;
              h           <= '0;
              seed_cnt    <= '0;
              locked_q    <= 1'b0;
              sync_lost_q <= 1'b1;
              win_bits    <= '0;
              win_errs    <= '0;
            end else begin
              h <= h_fly;
              if (win_end) begin
                win_bits <= '0;
                win_errs <= '0;
              end else begin
                win_bits <= win_bits + BW'(1);
                win_errs <= win_errs_nx;
              end
            end
          end

          default: state <= SEED;
        endcase
      end
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.sync_lost = sync_lost_q;
  assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_prbs_checker.sv
// Directed scoreboard bench for prbs_checker (LOCK_CNT=8, WINDOW=16, UNLOCK_ERR=4, CNT_W=2).
module tb_prbs_checker;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst_n;

  prbs_checker_if #(.CNT_W(CW)) bus ();

  prbs_checker #(
    .LOCK_CNT(8), .WINDOW(16), .UNLOCK_ERR(4), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          l;
    logic          e;
    logic          s;
    logic [CW-1:0] c;
    string         tag;
  } exp_t;

  exp_t       sbq[$];
  int         total  = 0;
  int         passed = 0;
  int         fails  = 0;
  int         gi     = 0;
  logic [6:0] pat    = 7'b0110001;  // stream 1000110, pat[i] = b[i]

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_now(input logic el, ee, es, input int ec, input string tag);
    exp_t x;
    x.l = el; x.e = ee; x.s = es; x.c = CW'(ec); x.tag = tag;
    sbq.push_back(x);
  endtask

  task automatic pop_check();
    exp_t x;
    if (sbq.size() == 0) begin
      cmp("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      x = sbq.pop_front();
      cmp({x.tag, ".locked"},    32'(bus.locked),    32'(x.l));
      cmp({x.tag, ".err"},       32'(bus.err),       32'(x.e));
      cmp({x.tag, ".sync_lost"}, 32'(bus.sync_lost), 32'(x.s));
      cmp({x.tag, ".err_count"}, 32'(bus.err_count), 32'(x.c));
    end
  endtask

  task automatic step(input logic d, v, c, el, ee, es, input int ec, input string tag);
    bus.din       = d;
    bus.din_valid = v;
    bus.clr_count = c;
    expect_now(el, ee, es, ec, tag);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  // Next generator bit, optionally inverted, sent as a valid bit.
  task automatic vbit(input logic inv, c, el, ee, es, input int ec, input string tag);
    logic b;
    b = pat[gi % 7] ^ inv;
    gi++;
    step(b, 1'b1, c, el, ee, es, ec, tag);
  endtask

  task automatic sync_reset();
    bus.din_valid = 1'b0;
    bus.clr_count = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    bus.clr_count = 1'b0;
    #12;
    expect_now(0, 0, 0, 0, "reset");
    pop_check();
    rst_n = 1'b1;

    // Acquire lock: 4 seed + 8 verified bits.
    for (int i = 1; i <= 12; i++) vbit(0, 0, i == 12, 0, 0, 0, "lock");
    for (int i = 0; i < 8; i++)   vbit(0, 0, 1, 0, 0, 0, "post_lock");

    // Single error, then flywheel through to the end of the first window.
    vbit(1, 0, 1, 1, 0, 1, "single_err");
    for (int i = 0; i < 7; i++) vbit(0, 0, 1, 0, 0, 1, "flywheel");

    // Four errors in a fresh window drop lock; counter saturates at 3.
    vbit(1, 0, 1, 1, 0, 2, "los1");
    vbit(1, 0, 1, 1, 0, 3, "los2");
    vbit(1, 0, 1, 1, 0, 3, "los3");
    vbit(1, 0, 0, 1, 1, 3, "los4");
    for (int i = 1; i <= 12; i++) vbit(0, 0, i == 12, 0, 0, 3, "relock");

    // Clear without a valid bit.
    step(1'b0, 1'b0, 1'b1, 1, 0, 0, 0, "clr_idle");

    // One error per window: count saturates and holds.
    for (int w = 0; w < 5; w++) begin
      vbit(1, 0, 1, 1, 0, (w + 1 > 3) ? 3 : w + 1, "sat_err");
      for (int i = 0; i < 15; i++) vbit(0, 0, 1, 0, 0, (w + 1 > 3) ? 3 : w + 1, "sat_clean");
    end

    // Clear coinciding with an error: err pulses, count is zero.
    vbit(1, 1, 1, 1, 0, 0, "clr_err");

    // Asynchronous reset between edges while err is high.
    bus.din_valid = 1'b0;
    bus.clr_count = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    expect_now(0, 0, 0, 0, "async_rst");
    pop_check();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Gapped valid: lock after the 12th valid bit, idle cycles change nothing.
    for (int i = 1; i <= 12; i++) begin
      vbit(0, 0, i == 12, 0, 0, 0, "gap_valid");
      step(1'($urandom_range(1)), 1'b0, 1'b0, i == 12, 0, 0, 0, "gap_idle");
    end

    // Constant-zero stream.
    sync_reset();
    for (int i = 1; i <= 100; i++) begin
`ifdef PRBS_ZERO_REJECT_EN
      step(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, "zero_reject");
`else
      step(1'b0, 1'b1, 1'b0, i >= 12, 0, 0, 0, "zero_lock");
`endif
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
